pc_fetch_unit: RTL

- Fetch-stage owner of the program counter: holds CurrentPC, drives the instruction-memory request/ack handshake, and loads the IF/ID pipeline register.
- Drives CurrentPC to the next-PC logic and takes its branch-target result back as RedirectPC/Redirect.
- Sequential PC+4 stepping, stall back-pressure through a one-entry skid buffer, and flush/redirect with correct discard of in-flight fetches.

---
 rtl/pc_fetch_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC owner: IMEM request/ack handshake, IF/ID register, one-entry skid buffer, redirect drain.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky FetchFault on misaligned redirect targets.
module pc_fetch_unit #(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic               CLK,
   input  logic               Reset_L,
   output logic               IMemReq,
   output logic [ADDR_W-1:0]  IMemAddr,
   input  logic               IMemAck,
   input  logic [INSTR_W-1:0] IMemData,
   input  logic               Stall,
   input  logic               Redirect,
   input  logic [ADDR_W-1:0]  RedirectPC,
   output logic [ADDR_W-1:0]  CurrentPC,
   output logic               IFIDValid,
   output logic [INSTR_W-1:0] IFIDInstr,
   output logic [ADDR_W-1:0]  IFIDPC
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic               FetchFault
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  target_q, target_d;
   logic               req_q, req_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
   logic               skid_valid_q, skid_valid_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
   logic [ADDR_W-1:0]  pc_plus4;
   logic               slot_free;
   logic               misalign;
   logic               faulted;

   assign pc_plus4  = pc_q + ADDR_W'(4);
   assign slot_free = !ifid_valid_q || !Stall;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q, fault_d;

   assign misalign   = Redirect && (RedirectPC[1:0] != 2'b00);
   assign faulted    = fault_q;
   assign fault_d    = fault_q || misalign;
   assign FetchFault = fault_q;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) fault_q <= 1'b0;
      else          fault_q <= fault_d;
   end
`else
   assign misalign = 1'b0;
   assign faulted  = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_d     = target_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      // Decode drains IF/ID whenever it is not stalled; a redirect flushes everything.
      if (ifid_valid_q && !Stall) ifid_valid_d = 1'b0;
      if (Redirect) begin
         ifid_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!faulted) begin
               state_d = FETCH;
               if (Redirect) begin
                  pc_d = RedirectPC;
                  if (misalign) state_d = IDLE;
               end
            end
         end
         FETCH: begin
            if (Redirect) begin
               if (IMemAck) begin
                  pc_d    = RedirectPC;
                  state_d = misalign ? IDLE : FETCH;
               end else begin
                  target_d = RedirectPC;
                  state_d  = DRAIN;
               end
            end else if (IMemAck) begin
               pc_d = pc_plus4;
               if (slot_free) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = IMemData;
                  ifid_pc_d    = pc_q;
               end else begin
                  skid_valid_d = 1'b1;
                  skid_instr_d = IMemData;
                  skid_pc_d    = pc_q;
                  state_d      = HOLD;
               end
            end
         end
         HOLD: begin
            if (Redirect) begin
               pc_d    = RedirectPC;
               state_d = misalign ? IDLE : FETCH;
            end else if (!Stall) begin
               ifid_valid_d = skid_valid_q;
               ifid_instr_d = skid_instr_q;
               ifid_pc_d    = skid_pc_q;
               skid_valid_d = 1'b0;
               state_d      = FETCH;
            end
         end
         DRAIN: begin
            // The stale request must complete with a stable address before moving on.
            if (IMemAck) begin
               pc_d    = Redirect ? RedirectPC : target_q;
               state_d = (faulted || misalign) ? IDLE : FETCH;
            end else if (Redirect) begin
               target_d = RedirectPC;
            end
         end
         default: state_d = IDLE;
      endcase

      req_d = (state_d == FETCH) || (state_d == DRAIN);
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         target_q     <= RESET_PC;
         req_q        <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         target_q     <= target_d;
         req_q        <= req_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign IMemReq   = req_q;
   assign IMemAddr  = pc_q;
   assign CurrentPC = pc_q;
   assign IFIDValid = ifid_valid_q;
   assign IFIDInstr = ifid_instr_q;
   assign IFIDPC    = ifid_pc_q;

endmodule
